fxp_arith_unit: RTL and testbench
=================================

Name: fxp_arith_unit

Overview:
- Clocked signed fixed-point arithmetic unit with add, subtract and divide on two independently formatted operands.
- Output is one configurable fixed-point format, with round-to-nearest and saturation.
- Add/sub finish in a single cycle; divide runs an iterative restoring divider under a start/busy/out_valid handshake.
- Sits in datapaths that need mixed-format fixed-point math and cannot afford a combinational divider.

Parameters:
- WIIA, 10: integer bits of operand A, sign included.
- WIFA, 11: fractional bits of operand A.
- WIIB, 8: integer bits of operand B, sign included.
- WIFB, 12: fractional bits of operand B.
- WOI, 9: integer bits of result, sign included.
- WOF, 10: fractional bits of result.
- ROUND, 1: 1 = round to nearest, ties toward +inf (half-up); 0 = truncate toward -inf.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  2  00 add (A+B), 01 sub (A-B), 10 div (A/B), 11 reserved (treated as add).
- ina  in  WIIA+WIFA  operand A (dividend), two's complement.
- inb  in  WIIB+WIFB  operand B (divisor), two's complement.
- busy  out  1  high while a division is in progress.
- out_valid  out  1  one-cycle pulse when out/overflow are updated.
- out  out  WOI+WOF  result, two's complement.
- overflow  out  1  result was saturated, or division by zero occurred.

Behaviour:
- Reset (async, any time): out=0, overflow=0, out_valid=0, busy=0, FSM in IDLE. A division in flight is abandoned and produces no out_valid.
- FSM states: IDLE, DIV_RUN, DIV_FIN.
- IDLE + start with op≠10:
  - Sign-extend/zero-pad both operands to a common format: max(WIIA,WIIB)+1 integer bits, max(WIFA,WIFB) fractional bits.
  - Add or subtract exactly (no intermediate overflow possible).
  - Round to WOF fractional bits (ROUND=1: add half-LSB, then truncate), then saturate to WOI integer bits.
  - Register out/overflow; out_valid=1 on the next cycle. Latency 1; throughput one op per cycle.
- IDLE + start with op=10:
  - Latch |A|, |B| and result sign = sign(A) xor sign(B); busy=1; enter DIV_RUN.
  - DIV_RUN: restoring division, one quotient bit per cycle, WOI+WOF+1 iterations. The extra LSB is the rounding bit; magnitudes are aligned so the quotient LSB weights 2^-(WOF+1). Go to DIV_FIN.
  - DIV_FIN: apply rounding to the magnitude, then negate if the sign is set, then saturate. Register out/overflow, out_valid=1, busy=0, back to IDLE.
  - Start to out_valid is WOI+WOF+3 cycles (22 with defaults), independent of operand values.
- Saturation:
  - Positive results above 2^(WOI-1)-2^-WOF clamp to max (0 followed by all ones).
  - Negative results below -2^(WOI-1) clamp to min (1 followed by all zeros).
  - overflow=1 whenever clamping occurs, else 0.
- Divide by zero (inb=0):
  - No iteration error.
  - Result = max positive if A≥0, min negative if A<0; overflow=1.
  - Same latency as a normal division.
- 0/nonzero returns 0, overflow=0. Negative zero never appears.
- start while busy=1 is ignored (no queuing). out/overflow hold their last value between results.
- Simultaneous start and DIV_FIN completion: the completion is reported; the start is ignored because busy is still high that cycle.

Optional Feature:
- Macro FXP_ARITH_DIVZERO_EN.
- When defined: adds output port div_by_zero (1 bit), which pulses with out_valid when a divide had inb=0, and resets to 0.
- When undefined: the port is absent, and divide-by-zero is reported only through overflow plus the saturated out value.

Test Plan (defaults, hex values are raw bit patterns):
- add: ina=0x00C00 (1.5), inb=0x02400 (2.25) -> next cycle out=0x00F00 (3.75), overflow=0, out_valid one pulse.
- sub: same operands, op=01 -> out=0x7FD00 (-0.75), overflow=0.
- add saturation: ina=0x64000 (200.0), inb=0x64000 (100.0) -> out=0x3FFFF, overflow=1.
- rounding: ina=0x00001 (2^-11), inb=0, add -> out=0x00001 with ROUND=1; out=0x00000 with ROUND=0.
- divide: ina=0x01800 (3.0), inb=0x02000 (2.0) -> busy high 21 cycles, out=0x00600 (1.5) with out_valid 22 cycles after start; a second start mid-division is ignored.
- divide by zero, then reset:
  - ina=0x1FF800 (-1.0), inb=0 -> out=0x40000, overflow=1 (div_by_zero=1 if enabled).
  - Assert rst mid-division -> busy=0, out=0 immediately, no out_valid.

Source files
------------

// File: rtl/fxp_arith_unit.sv
// Signed fixed-point add/sub (1 cycle) and iterative restoring divide.
// Define FXP_ARITH_DIVZERO_EN to add the div_by_zero output pulse.
module fxp_arith_unit #(
    parameter int WIIA  = 10,
    parameter int WIFA  = 11,
    parameter int WIIB  = 8,
    parameter int WIFB  = 12,
    parameter int WOI   = 9,
    parameter int WOF   = 10,
    parameter int ROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WIIA+WIFA-1:0]   ina,
    input  logic [WIIB+WIFB-1:0]   inb,
    output logic                   busy,
    output logic                   out_valid,
    output logic [WOI+WOF-1:0]     out,
    output logic                   overflow
`ifdef FXP_ARITH_DIVZERO_EN
    ,
    output logic                   div_by_zero
`endif
);
    localparam int AW  = WIIA + WIFA;
    localparam int BW  = WIIB + WIFB;
    localparam int OW  = WOI + WOF;
    localparam int CI  = ((WIIA > WIIB) ? WIIA : WIIB) + 1;
    localparam int CF  = (WIFA > WIFB) ? WIFA : WIFB;
    localparam int FF  = (CF > WOF) ? CF : WOF + 1;
    localparam int SI  = ((CI > WOI) ? CI : WOI) + 1;
    localparam int SW  = SI + FF;
    localparam int NQ  = OW + 1;
    localparam int SH  = WIFB - WIFA + WOF + 1;
    localparam int SA  = (SH > 0) ? SH : 0;
    localparam int SB  = (SH < 0) ? -SH : 0;
    localparam int NW  = AW + SA;
    localparam int DW  = BW + SB + NQ - 1;
    localparam int W   = ((NW > DW) ? NW : DW) + 1;
    localparam int CNW = $clog2(NQ);

    localparam logic signed [SW-1:0] MAXS = SW'({(OW-1){1'b1}});
    localparam logic signed [SW-1:0] MINS = ~MAXS;
    localparam logic [SW-1:0] HALF =
        (ROUND != 0) ? (SW'(1) << (FF - WOF - 1)) : '0;

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIN} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     r_q, r_d, dsh_q, dsh_d, db_q, db_d;
    logic [NQ-1:0]    q_q, q_d;
    logic [CNW-1:0]   cnt_q, cnt_d;
    logic             neg_q, neg_d, dz_q, dz_d;
    logic [OW-1:0]    out_q, out_d;
    logic             ovf_q, ovf_d, vld_q, vld_d;

    function automatic logic [OW:0] saturate(input logic signed [SW-1:0] v);
        if (v > MAXS) return {1'b1, MAXS[OW-1:0]};
        if (v < MINS) return {1'b1, MINS[OW-1:0]};
        return {1'b0, v[OW-1:0]};
    endfunction

    logic signed [SW-1:0] a_ext, b_ext, sum, rnd;
    logic [OW:0]          add_sat;

    always_comb begin
        a_ext = $signed({{(SW-AW){ina[AW-1]}}, ina}) <<< (FF - WIFA);
        b_ext = $signed({{(SW-BW){inb[BW-1]}}, inb}) <<< (FF - WIFB);
        sum   = (op == 2'b01) ? a_ext - b_ext : a_ext + b_ext;
        rnd   = (sum + $signed(HALF)) >>> (FF - WOF);
        add_sat = saturate(rnd);
    end

    logic [AW-1:0]        abs_a;
    logic [BW-1:0]        abs_b;
    logic [NQ:0]          q_inc;
    logic [NQ-1:0]        mag;
    logic signed [SW-1:0] dval;
    logic                 qov;
    logic [OW:0]          div_sat;

    always_comb begin
        abs_a = ina[AW-1] ? -ina : ina;
        abs_b = inb[BW-1] ? -inb : inb;
        q_inc = {1'b0, q_q} + {{NQ{1'b0}}, (ROUND != 0)};
        mag   = q_inc[NQ:1];
        dval  = neg_q ? -$signed(SW'(mag)) : $signed(SW'(mag));
        // Quotient did not fit NQ bits, or divisor was zero.
        qov   = dz_q || (r_q >= db_q);
        if (qov)
            div_sat = {1'b1, neg_q ? MINS[OW-1:0] : MAXS[OW-1:0]};
        else
            div_sat = saturate(dval);
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dsh_d   = dsh_q;
        db_d    = db_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && op == 2'b10) begin
                    r_d     = W'(abs_a) << SA;
                    db_d    = W'(abs_b) << SB;
                    dsh_d   = W'(abs_b) << (SB + NQ - 1);
                    q_d     = '0;
                    cnt_d   = CNW'(NQ - 1);
                    dz_d    = (inb == '0);
                    neg_d   = (inb == '0) ? ina[AW-1]
                                          : ina[AW-1] ^ inb[BW-1];
                    state_d = DIV_RUN;
                end else if (start) begin
                    out_d = add_sat[OW-1:0];
                    ovf_d = add_sat[OW];
                    vld_d = 1'b1;
                end
            end
            DIV_RUN: begin
                if (r_q >= dsh_q) begin
                    r_d = r_q - dsh_q;
                    q_d = {q_q[NQ-2:0], 1'b1};
                end else begin
                    q_d = {q_q[NQ-2:0], 1'b0};
                end
                dsh_d = dsh_q >> 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DIV_FIN;
            end
            DIV_FIN: begin
                out_d   = div_sat[OW-1:0];
                ovf_d   = div_sat[OW];
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            dsh_q   <= '0;
            db_q    <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dsh_q   <= dsh_d;
            db_q    <= db_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

`ifdef FXP_ARITH_DIVZERO_EN
    logic dzo_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dzo_q <= 1'b0;
        else     dzo_q <= (state_q == DIV_FIN) && dz_q;
    end
    assign div_by_zero = dzo_q;
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign out       = out_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_fxp_arith_unit.sv
// Directed-vector bench for fxp_arith_unit at default parameters.
// Covers add/sub, rounding, saturation, divide, div-by-zero, reset.
module tb_fxp_arith_unit;
    localparam int RND = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [20:0] ina = '0;
    logic [19:0] inb = '0;
    logic        busy, out_valid, overflow;
    logic [18:0] out;
`ifdef FXP_ARITH_DIVZERO_EN
    logic        dz;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fxp_arith_unit #(.ROUND(RND)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .ina(ina),
        .inb(inb),
        .busy(busy),
        .out_valid(out_valid),
        .out(out),
        .overflow(overflow)
`ifdef FXP_ARITH_DIVZERO_EN
        ,
        .div_by_zero(dz)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [20:0] a,
                         input logic [19:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        ina   = a;
        inb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_add(input string tag, input logic [1:0] o,
                           input logic [20:0] a, input logic [19:0] b,
                           input logic [18:0] eo, input logic eov);
        issue(o, a, b);
        check({tag, " vld"}, out_valid, 1);
        check({tag, " out"}, out, eo);
        check({tag, " ovf"}, overflow, eov);
    endtask

    task automatic run_div(input string tag, input logic [20:0] a,
                           input logic [19:0] b, input logic [18:0] eo,
                           input logic eov, input logic edz);
        int n;
        issue(2'b10, a, b);
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " lat"}, n, 22);
        check({tag, " out"}, out, eo);
        check({tag, " ovf"}, overflow, eov);
`ifdef FXP_ARITH_DIVZERO_EN
        check({tag, " dz"}, dz, edz);
`else
        if (edz) n_tests = n_tests + 0;
`endif
    endtask

    initial begin
        int n, bc, cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst out", out, 0);
        check("rst ovf", overflow, 0);
        check("rst vld", out_valid, 0);
        check("rst busy", busy, 0);

        run_add("add", 2'b00, 21'h00C00, 20'h02400, 19'h00F00, 0);
        @(posedge clk);
        #1;
        check("add pulse", out_valid, 0);
        check("add hold", out, 19'h00F00);
        run_add("sub", 2'b01, 21'h00C00, 20'h02400, 19'h7FD00, 0);
        run_add("op11", 2'b11, 21'h00C00, 20'h02400, 19'h00F00, 0);
        run_add("satp", 2'b00, 21'h64000, 20'h64000, 19'h3FFFF, 1);
        run_add("satn", 2'b00, 21'h100000, 20'h00000, 19'h40000, 1);
        run_add("rnd", 2'b00, 21'h00001, 20'h00000,
                (RND != 0) ? 19'h00001 : 19'h00000, 0);
        run_add("tie", 2'b00, 21'h1FFFFF, 20'h00000,
                (RND != 0) ? 19'h00000 : 19'h7FFFF, 0);

        issue(2'b10, 21'h01800, 20'h02000);
        check("div busy0", busy, 1);
        n  = 1;
        bc = busy ? 1 : 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            if (n == 5 || n == 21) begin
                start = 1'b1;
                op    = 2'b00;
                ina   = 21'h00C00;
                inb   = 20'h02400;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        start = 1'b0;
        check("div lat", n, 22);
        check("div busy", bc, 21);
        check("div out", out, 19'h00600);
        check("div ovf", overflow, 0);
        check("div idle", busy, 0);
        @(posedge clk);
        #1;
        check("div ign vld", out_valid, 0);
        check("div ign out", out, 19'h00600);

        run_div("dneg", 21'h1FE800, 20'h02000, 19'h7FA00, 0, 0);
        run_div("third", 21'h00800, 20'h03000, 19'h00155, 0, 0);
        run_div("dsat", 21'h64000, 20'h00800, 19'h3FFFF, 1, 0);
        run_div("dbig", 21'h64000, 20'h00001, 19'h3FFFF, 1, 0);
        run_div("zero", 21'h00000, 20'h02000, 19'h00000, 0, 0);
        run_div("dz neg", 21'h1FF800, 20'h00000, 19'h40000, 1, 1);
        run_div("dz pos", 21'h01800, 20'h00000, 19'h3FFFF, 1, 1);

        issue(2'b10, 21'h01800, 20'h02000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst out", out, 0);
        check("arst ovf", overflow, 0);
        check("arst vld", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check("arst novld", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
